// File: rtl/hex_value_entry_if.sv
// Hex value entry bus: keypad/button inputs and edited/committed value outputs.
//   slave  : the entry controller (drives o_* signals, reads i_* signals)
//   master : the environment (switches, buttons, display/consumer)
// Signals:
//   i_key_digit   4  hex digit from switches
//   i_btn_*       1  raw bouncing pushbuttons (push/back/enter/clear), active-high
//   o_entry_val  32  value being edited
//   o_digit_count 4  digits currently in o_entry_val
//   o_val        32  last committed value
//   o_val_valid   1  one-cycle pulse when o_val updates
//   o_full        1  entry holds the maximum number of digits
//   o_reject      1  one-cycle pulse when a button event is refused
interface hex_value_entry_if;
  logic [3:0]  i_key_digit;
  logic        i_btn_push;
  logic        i_btn_back;
  logic        i_btn_enter;
  logic        i_btn_clear;
  logic [31:0] o_entry_val;
  logic [3:0]  o_digit_count;
  logic [31:0] o_val;
  logic        o_val_valid;
  logic        o_full;
  logic        o_reject;

  modport slave (
    input  i_key_digit, i_btn_push, i_btn_back, i_btn_enter, i_btn_clear,
    output o_entry_val, o_digit_count, o_val, o_val_valid, o_full, o_reject
  );

  modport master (
    output i_key_digit, i_btn_push, i_btn_back, i_btn_enter, i_btn_clear,
    input  o_entry_val, o_digit_count, o_val, o_val_valid, o_full, o_reject
  );
endinterface

// File: rtl/hex_value_entry.sv
// Hex value entry controller: four pushbuttons are synchronized and debounced,
// and their debounced rising edges edit a hex value digit by digit.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  hex_value_entry_if.slave (buttons/key in, entry/commit outputs)
//
// state | meaning
// EMPTY | digit_count == 0
// EDIT  | 0 < digit_count < MAX_DIGITS
// FULL  | digit_count == MAX_DIGITS
module hex_value_entry #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int MAX_DIGITS      = 6
) (
  input  logic                clk,
  input  logic                rst,
  hex_value_entry_if.slave    bus
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_EDIT  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int          CW     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LP_TC = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]  LP_MAX = 4'(MAX_DIGITS);

  // Button index: 0 push, 1 back, 2 enter, 3 clear (also priority order, high last)
  logic [3:0]    w_btn_raw;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_deb;
  logic [3:0]    r_deb_d;
  logic [CW-1:0] r_cnt [4];
  logic [3:0]    w_ev;

  logic [1:0]  r_state;
  logic [31:0] r_entry_val;
  logic [3:0]  r_digit_count;
  logic [31:0] r_val;
  logic        r_val_valid;
  logic        r_full;
  logic        r_reject;

  logic [31:0] w_entry_nxt;
  logic [3:0]  w_count_nxt;
  logic [31:0] w_val_nxt;
  logic        w_vv_nxt;
  logic        w_rej_nxt;
  logic [1:0]  w_state_nxt;

  assign w_btn_raw = {bus.i_btn_clear, bus.i_btn_enter, bus.i_btn_back, bus.i_btn_push};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int b = 0; b < 4; b++) r_cnt[b] <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      for (int b = 0; b < 4; b++) begin
        if (r_sync2[b] == r_deb[b]) begin
          r_cnt[b] <= '0;
        end else if (r_cnt[b] == LP_TC) begin
          // This is the DEBOUNCE_CYCLES-th consecutive differing cycle
          r_cnt[b] <= '0;
          r_deb[b] <= ~r_deb[b];
        end else begin
          r_cnt[b] <= r_cnt[b] + 1'b1;
        end
      end
    end
  end

  // Only debounced rising edges are events
  assign w_ev = r_deb & ~r_deb_d;

  always_comb begin
    w_entry_nxt = r_entry_val;
    w_count_nxt = r_digit_count;
    w_val_nxt   = r_val;
    w_vv_nxt    = 1'b0;
    w_rej_nxt   = 1'b0;
    if (w_ev[3]) begin
      w_entry_nxt = '0;
      w_count_nxt = '0;
    end else if (w_ev[2]) begin
      if (r_state == ST_EMPTY) begin
        w_rej_nxt = 1'b1;
      end else begin
        w_val_nxt   = r_entry_val;
        w_vv_nxt    = 1'b1;
        w_entry_nxt = '0;
        w_count_nxt = '0;
      end
    end else if (w_ev[1]) begin
      if (r_state == ST_EMPTY) begin
        w_rej_nxt = 1'b1;
      end else begin
        w_entry_nxt = r_entry_val >> 4;
        w_count_nxt = r_digit_count - 4'd1;
      end
    end else if (w_ev[0]) begin
      if (r_state == ST_FULL) begin
        w_rej_nxt = 1'b1;
      end else begin
        w_entry_nxt = {r_entry_val[27:0], bus.i_key_digit};
        w_count_nxt = r_digit_count + 4'd1;
      end
    end

    if (w_count_nxt == 4'd0)        w_state_nxt = ST_EMPTY;
    else if (w_count_nxt == LP_MAX) w_state_nxt = ST_FULL;
    else                            w_state_nxt = ST_EDIT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_EMPTY;
      r_entry_val   <= '0;
      r_digit_count <= '0;
      r_val         <= '0;
      r_val_valid   <= 1'b0;
      r_full        <= 1'b0;
      r_reject      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_entry_val   <= w_entry_nxt;
      r_digit_count <= w_count_nxt;
      r_val         <= w_val_nxt;
      r_val_valid   <= w_vv_nxt;
      r_full        <= (w_state_nxt == ST_FULL);
      r_reject      <= w_rej_nxt;
    end
  end

  assign bus.o_entry_val   = r_entry_val;
  assign bus.o_digit_count = r_digit_count;
  assign bus.o_val         = r_val;
  assign bus.o_val_valid   = r_val_valid;
  assign bus.o_full        = r_full;
  assign bus.o_reject      = r_reject;

endmodule

// File: doc/hex_value_entry.md
HEX_VALUE_ENTRY -- requirements
Module: hex_value_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, is the number of consecutive stable cycles required to accept a button change (minimum 2).
REQ-002 Parameter MAX_DIGITS, default 6, is the maximum number of hex digits accepted per entry (range 1..8).
REQ-003 clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 key_digit  input  4  hex digit from the switches, sampled when a push event is applied.
REQ-006 btn_push, btn_back, btn_enter, btn_clear  input  1 each  raw, asynchronous, bouncing pushbuttons, active-high.
REQ-007 entry_val  output  32  value being edited; feeds the display path.
REQ-008 digit_count  output  4  number of digits currently in entry_val.
REQ-009 val  output  32  last committed value.
REQ-010 val_valid  output  1  one-cycle pulse when val updates.
REQ-011 full  output  1  high when digit_count == MAX_DIGITS.
REQ-012 reject  output  1  one-cycle pulse when a button event is refused.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then a debouncer.
REQ-014 Debouncer: a per-button counter counts cycles where the synchronized input differs from the debounced state; it clears on any match; the debounced state toggles when the count reaches DEBOUNCE_CYCLES.
REQ-015 An event SHALL be the debounced rising edge only; releases and holds generate nothing.
REQ-016 Outputs SHALL reflect an event exactly DEBOUNCE_CYCLES+3 cycles after a clean raw rising edge.
REQ-017 Simultaneous events in one cycle: only the highest-priority event is applied (clear > enter > back > push); the others are dropped without reject.
REQ-018 FSM states:
- EMPTY: digit_count == 0.
- EDIT: 0 < digit_count < MAX_DIGITS.
- FULL: digit_count == MAX_DIGITS.
REQ-019 push in EMPTY/EDIT: entry_val <= {entry_val[27:0], key_digit}; digit_count increments; the FSM moves to EDIT or FULL.
REQ-020 push in FULL: no state change; reject pulses.
REQ-021 back in EDIT/FULL: entry_val <= entry_val >> 4; digit_count decrements; the FSM moves to EMPTY or EDIT.
REQ-022 back in EMPTY: reject pulses.
REQ-023 enter in EDIT/FULL:
- val <= entry_val; val_valid pulses.
- entry_val, digit_count <= 0; the FSM moves to EMPTY.
REQ-024 enter in EMPTY: reject pulses; val is unchanged.
REQ-025 clear in any state: entry_val, digit_count <= 0; the FSM moves to EMPTY; val is retained; no reject.
REQ-026 entry_val bits above 4*digit_count SHALL always be zero.
REQ-027 Arithmetic SHALL be unsigned with no wrap; digit_count never exceeds MAX_DIGITS and never underflows.
REQ-028 full SHALL be a registered decode of the FULL state.

Reset
REQ-029 On rst high, the following SHALL clear immediately, independent of clk:
- entry_val, digit_count, val, val_valid, reject, full;
- synchronizers, debounce counters and debounced states.
REQ-030 After rst, the FSM SHALL be in EMPTY.
REQ-031 A button held high through reset release SHALL produce exactly one event, DEBOUNCE_CYCLES+3 cycles after release, because the debounced state resets low.
REQ-032 Reset asserted mid-debounce SHALL discard the pending event; no late event follows.

Verification (DEBOUNCE_CYCLES=4, MAX_DIGITS=6)
REQ-033 Push digits 1,2,3 -> entry_val=0x123, digit_count=3; each push takes effect 7 cycles after its raw rise.
REQ-034 Push digits A,B,C,D,E,F, then 7 -> entry_val=0xABCDEF, full=1; the 7th push gives a reject pulse with entry_val unchanged.
REQ-035 From 0x123, back then enter -> val=0x12 with a one-cycle val_valid; entry_val=0, digit_count=0.
REQ-036 Raw btn_push glitches of 1-3 cycles, repeated -> no event, entry_val unchanged.
REQ-037 btn_enter and btn_push rise together with entry 0x5 -> val=0x5 commits; the push is dropped; entry_val=0.
REQ-038 Assert rst between clock edges during EDIT -> all outputs are 0 before the next edge; enter in EMPTY afterward -> reject, val stays 0.
